// File: rtl/sram_port_arbiter_if.sv
// Bundles the two requester ports, their response channels and the single-port SRAM
// (RW0) signals. The arbiter uses the slave view; requesters, SRAM and bench use master.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 128,
    parameter int MASK_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [MASK_W-1:0] req0_wmask;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [MASK_W-1:0] req1_wmask;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              init_done;

    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output init_done,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  init_done,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM, with an optional
// zero-fill of the whole array after reset before any requester is served.
module sram_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 128,
    parameter int MASK_W  = 4,
    parameter int INIT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    sram_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        WAIT,
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] init_cnt_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic              grant0;
    logic              grant1;
    logic              rsp0_pend;
    logic              rsp1_pend;

    // last_grant resets to 1 so that req0 wins the first contention after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= WAIT;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            rsp0_pend  <= 1'b0;
            rsp1_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            last_grant <= last_grant_nxt;
            rsp0_pend  <= grant0 && !bus.req0_write;
            rsp1_pend  <= grant1 && !bus.req1_write;
        end
    end

    always_comb begin
        state_nxt      = state;
        init_cnt_nxt   = init_cnt;
        last_grant_nxt = last_grant;
        grant0         = 1'b0;
        grant1         = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_wmode = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wmask = '0;
        bus.sram_wdata = '0;

        case (state)
            WAIT: begin
                state_nxt = (INIT_EN != 0) ? INIT : RUN;
            end
            INIT: begin
                bus.sram_en    = 1'b1;
                bus.sram_wmode = 1'b1;
                bus.sram_addr  = init_cnt;
                bus.sram_wmask = '1;
                bus.sram_wdata = '0;
                // Stop on the last address instead of wrapping the counter.
                if (init_cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                end else begin
                    init_cnt_nxt = init_cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
                grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
                if (grant0) begin
                    bus.sram_en    = 1'b1;
                    bus.sram_wmode = bus.req0_write;
                    bus.sram_addr  = bus.req0_addr;
                    bus.sram_wmask = bus.req0_wmask;
                    bus.sram_wdata = bus.req0_wdata;
                    last_grant_nxt = 1'b0;
                end else if (grant1) begin
                    bus.sram_en    = 1'b1;
                    bus.sram_wmode = bus.req1_write;
                    bus.sram_addr  = bus.req1_addr;
                    bus.sram_wmask = bus.req1_wmask;
                    bus.sram_wdata = bus.req1_wdata;
                    last_grant_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT;
            end
        endcase
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.init_done  = (state == RUN);
    assign bus.rsp0_valid = rsp0_pend;
    assign bus.rsp1_valid = rsp1_pend;
    assign bus.rsp0_rdata = bus.sram_rdata;
    assign bus.rsp1_rdata = bus.sram_rdata;

endmodule
